// File: rtl/ex4511_148_seg_if.sv
// Request/segment bundle for ex4511_148_seg: active-low request banks in,
// registered segment readout and cascade flags out.
interface ex4511_148_seg_if;
    logic [7:0] in_15_8;
    logic [7:0] in_7_0;
    logic [7:0] Seg;
    logic       EO_N;
    logic       GS_N;

    modport master (
        output in_15_8,
        output in_7_0,
        input  Seg,
        input  EO_N,
        input  GS_N
    );

    modport slave (
        input  in_15_8,
        input  in_7_0,
        output Seg,
        output EO_N,
        output GS_N
    );
endinterface

// File: rtl/ex4511_148_seg.sv
// Two cascaded 74x148 priority encoders feeding a 4511-style seven-segment decoder.
// Define HEX_DISPLAY_EN to show A..F for indices 10..15 instead of blanking them.
module ex4511_148_seg (
    input  logic                clk,
    input  logic                rst,
    ex4511_148_seg_if.slave     bus
);

    logic [2:0] up_code_n;
    logic       up_gs_n;
    logic       up_eo_n;
    logic [2:0] lo_code_n;
    logic       lo_gs_n;
    logic       lo_eo_n;
    logic [3:0] index;
    logic       gs_n;
    logic [6:0] digit;
    logic [7:0] seg_next;

    // Upper encoder: enable tied active, so EO_N low only when its bank is idle.
    always_comb begin
        up_code_n = '1;
        up_gs_n   = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!bus.in_15_8[i]) begin
                up_code_n = ~3'(i);
                up_gs_n   = 1'b0;
            end
        end
        up_eo_n = ~up_gs_n;
    end

    // Lower encoder: EI_N driven by upper EO_N; a disabled '148 drives all outputs high.
    always_comb begin
        lo_code_n = '1;
        lo_gs_n   = 1'b1;
        lo_eo_n   = 1'b1;
        if (!up_eo_n) begin
            lo_eo_n = 1'b0;
            for (int unsigned i = 0; i < 8; i++) begin
                if (!bus.in_7_0[i]) begin
                    lo_code_n = ~3'(i);
                    lo_gs_n   = 1'b0;
                    lo_eo_n   = 1'b1;
                end
            end
        end
    end

    // Active-low code lines combine by AND, as the inactive encoder sits at 111.
    assign index = {~up_gs_n, ~(up_code_n & lo_code_n)};
    assign gs_n  = up_gs_n & lo_gs_n;

    always_comb begin
        digit = '0;
        case (index)
            4'd0:  digit = 7'h3F;
            4'd1:  digit = 7'h06;
            4'd2:  digit = 7'h5B;
            4'd3:  digit = 7'h4F;
            4'd4:  digit = 7'h66;
            4'd5:  digit = 7'h6D;
            4'd6:  digit = 7'h7D;
            4'd7:  digit = 7'h07;
            4'd8:  digit = 7'h7F;
            4'd9:  digit = 7'h6F;
`ifdef HEX_DISPLAY_EN
            4'd10: digit = 7'h77;
            4'd11: digit = 7'h7C;
            4'd12: digit = 7'h39;
            4'd13: digit = 7'h5E;
            4'd14: digit = 7'h79;
            4'd15: digit = 7'h71;
`else
            default: digit = '0;
`endif
        endcase
    end

    // GS_N acts as the 4511 blanking input, so an idle bank shows nothing.
    assign seg_next = gs_n ? 8'h00 : {~up_gs_n, digit};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.Seg  <= '0;
            bus.GS_N <= 1'b1;
            bus.EO_N <= 1'b1;
        end else begin
            bus.Seg  <= seg_next;
            bus.GS_N <= gs_n;
            bus.EO_N <= lo_eo_n;
        end
    end

endmodule

// File: tb/tb_ex4511_148_seg.sv
// Randomized self-checking bench for ex4511_148_seg against a table-driven
// priority/segment reference model.
module tb_ex4511_148_seg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [7:0] exp_seg;
    logic       exp_gs_n;
    logic       exp_eo_n;
    logic [6:0] pat [16];

    ex4511_148_seg_if bus ();

    ex4511_148_seg dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_tests++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (in_15_8=%02h in_7_0=%02h)",
                     tag, observed, expected, bus.in_15_8, bus.in_7_0);
        end
    endtask

    // Reference: concatenate both banks, scan from request 15 down for the first low bit.
    task automatic model(input logic [7:0] hi, input logic [7:0] lo);
        logic [15:0] req;
        int winner;
        req    = {hi, lo};
        winner = -1;
        for (int k = 15; k >= 0; k--) begin
            if (winner < 0 && req[k] == 1'b0) winner = k;
        end
        if (winner < 0) begin
            exp_seg  = 8'h00;
            exp_gs_n = 1'b1;
            exp_eo_n = 1'b0;
        end else begin
            exp_seg  = {(winner >= 8) ? 1'b1 : 1'b0, pat[winner]};
            exp_gs_n = 1'b0;
            exp_eo_n = 1'b1;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".seg"}, bus.Seg, exp_seg);
        check({tag, ".gs"},  {7'd0, bus.GS_N}, {7'd0, exp_gs_n});
        check({tag, ".eo"},  {7'd0, bus.EO_N}, {7'd0, exp_eo_n});
    endtask

    // Drive mid-cycle, confirm outputs still hold the previous result, then check after the edge.
    task automatic apply(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        @(negedge clk);
        bus.in_15_8 = hi;
        bus.in_7_0  = lo;
        #1;
        check_outputs({tag, ".hold"});
        model(hi, lo);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] hi;
        logic [7:0] lo;
        logic [15:0] one_hot_n;

        pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
        pat[4] = 7'h66; pat[5] = 7'h6D; pat[6] = 7'h7D; pat[7] = 7'h07;
        pat[8] = 7'h7F; pat[9] = 7'h6F;
`ifdef HEX_DISPLAY_EN
        pat[10] = 7'h77; pat[11] = 7'h7C; pat[12] = 7'h39;
        pat[13] = 7'h5E; pat[14] = 7'h79; pat[15] = 7'h71;
`else
        for (int k = 10; k < 16; k++) pat[k] = 7'h00;
`endif

        bus.in_15_8 = 8'h00;
        bus.in_7_0  = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_seg = 8'h00; exp_gs_n = 1'b1; exp_eo_n = 1'b1;
        check_outputs("reset");

        @(negedge clk);
        rst = 1'b0;
        model(8'h00, 8'h00);
        @(posedge clk);
        #1;
        check_outputs("release");

        apply("w12a",   8'hE0, 8'hE0);
        apply("w12b",   8'hE3, 8'h1F);
        apply("w11",    8'hF0, 8'hE0);
        apply("idle",   8'hFF, 8'hFF);
        apply("w7",     8'hFF, 8'h1F);
        apply("w0",     8'hFF, 8'hFE);

        for (int k = 0; k < 16; k++) begin
            one_hot_n = 16'hFFFF;
            one_hot_n[k] = 1'b0;
            apply($sformatf("sweep%0d", k), one_hot_n[15:8], one_hot_n[7:0]);
        end

        for (int n = 0; n < 300; n++) begin
            hi = 8'($urandom);
            lo = 8'($urandom);
            case ($urandom_range(0, 3))
                0: hi = 8'hFF;
                1: hi = 8'hFF | (8'h01 << $urandom_range(0, 7));
                2: lo = 8'hFF;
                default: ;
            endcase
            if ($urandom_range(0, 9) == 0) begin
                hi = 8'hFF;
                lo = 8'hFF;
            end
            apply("rand", hi, lo);
        end

        // Reset asserted with requests present must still win that cycle.
        @(negedge clk);
        bus.in_15_8 = 8'h7F;
        bus.in_7_0  = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_seg = 8'h00; exp_gs_n = 1'b1; exp_eo_n = 1'b1;
        check_outputs("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        model(8'h7F, 8'h00);
        @(posedge clk);
        #1;
        check_outputs("rst_rel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
